// File: rtl/param_seq_detector.sv
// Parametrised Mealy sequence detector with runtime-loadable pattern, framed or sliding
// compare, input-valid qualifier and a saturating match counter.
module param_seq_detector #(
    parameter int SEQ_LEN = 4,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic               in,
    input  logic               pat_load,
    input  logic [SEQ_LEN-1:0] pattern,
    input  logic               mode,
    output logic               dec,
    output logic [CNT_W-1:0]   match_cnt
);

    localparam int PW = $clog2(SEQ_LEN);
    localparam logic [PW-1:0] LAST = PW'(SEQ_LEN - 1);

    typedef enum logic {
        MATCH = 1'b0,
        FAIL  = 1'b1
    } state_t;

    state_t             state_reg, state_next;
    logic [PW-1:0]      pos_reg, pos_next;
    logic [PW-1:0]      fill_reg, fill_next;
    logic [SEQ_LEN-2:0] hist_reg, hist_next, hist_shift;
    logic [SEQ_LEN-1:0] pat_reg;
    logic               mode_reg;
    logic [PW-1:0]      bit_idx;
    logic               bit_ok;
    logic               bit_take;

    // A 2-bit pattern keeps a single history bit, so there is nothing to shift along.
    generate
        if (SEQ_LEN == 2) begin : g_hist_short
            assign hist_shift = in;
        end else begin : g_hist_long
            assign hist_shift = {hist_reg[SEQ_LEN-3:0], in};
        end
    endgenerate

    assign bit_take = in_valid & ~pat_load & ~rst;
    assign bit_idx  = LAST - pos_reg;
    assign bit_ok   = (in == pat_reg[bit_idx]);

    always_comb begin
        state_next = state_reg;
        pos_next   = pos_reg;
        fill_next  = fill_reg;
        hist_next  = hist_reg;
        dec        = 1'b0;
        if (bit_take) begin
            if (!mode_reg) begin
                if (pos_reg == LAST) begin
                    dec        = (state_reg == MATCH) && bit_ok;
                    pos_next   = '0;
                    state_next = MATCH;
                end else begin
                    pos_next = pos_reg + 1'b1;
                    if (!bit_ok) begin
                        state_next = FAIL;
                    end
                end
            end else begin
                hist_next = hist_shift;
                if (fill_reg != LAST) begin
                    fill_next = fill_reg + 1'b1;
                end
                dec = (fill_reg == LAST) && ({hist_reg, in} == pat_reg);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pat_reg   <= '0;
            mode_reg  <= 1'b0;
            state_reg <= MATCH;
            pos_reg   <= '0;
            fill_reg  <= '0;
            hist_reg  <= '0;
            match_cnt <= '0;
        end else begin
            if (pat_load) begin
                pat_reg   <= pattern;
                mode_reg  <= mode;
                state_reg <= MATCH;
                pos_reg   <= '0;
                fill_reg  <= '0;
                hist_reg  <= '0;
            end else begin
                state_reg <= state_next;
                pos_reg   <= pos_next;
                fill_reg  <= fill_next;
                hist_reg  <= hist_next;
            end
            // Counter holds at all-ones instead of wrapping.
            if (dec && (match_cnt != '1)) begin
                match_cnt <= match_cnt + 1'b1;
            end
        end
    end

endmodule
